// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-bit shift/rotate sequencer and its step unit.
// Optional build macro: SHIFT_SEQ_RC_MOD_EN (reduce rcl/rcr counts to the rotate period).
package shift_seq_pkg;

  localparam logic [3:0] OP_ROL  = 4'd0;
  localparam logic [3:0] OP_ROR  = 4'd1;
  localparam logic [3:0] OP_RCL  = 4'd2;
  localparam logic [3:0] OP_RCR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SAL  = 4'd6;
  localparam logic [3:0] OP_SAR  = 4'd7;
  localparam logic [3:0] OP_SHRD = 4'd8;
  localparam logic [3:0] OP_SHLD = 4'd9;

  localparam logic [3:0] SZ_BYTE  = 4'd1;
  localparam logic [3:0] SZ_WORD  = 4'd2;
  localparam logic [3:0] SZ_DWORD = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } step_t;

  function automatic logic [31:0] size_mask(input logic [3:0] sz);
    case (sz)
      SZ_DWORD: size_mask = 32'hFFFF_FFFF;
      SZ_WORD:  size_mask = 32'h0000_FFFF;
      default:  size_mask = 32'h0000_00FF;
    endcase
  endfunction

  // Rotate-through-carry repeats every width+1 steps, so the count can be trimmed.
  function automatic logic [4:0] eff_count(input logic [3:0] op, input logic [3:0] sz,
                                           input logic [4:0] cnt);
    eff_count = cnt;
`ifdef SHIFT_SEQ_RC_MOD_EN
    if (op == OP_RCL || op == OP_RCR) begin
      if (sz == SZ_WORD)
        eff_count = cnt % 5'd17;
      else if (sz != SZ_DWORD)
        eff_count = cnt % 5'd9;
    end
`else
    if (op == 4'd15 && sz == 4'd15) eff_count = cnt;
`endif
  endfunction

endpackage

// File: rtl/shift_seq_shiftbox.sv
// Combinational shift step unit: one-bit and four-bit steps of the selected operation.
// Bits above the operand size pass through; rotates leave the carry untouched.
module shiftbox
  import shift_seq_pkg::*;
(
  input  logic [3:0]  shiftop,
  input  logic [3:0]  calc_sz,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        ci,
  output logic [31:0] resa,
  output logic [31:0] resb,
  output logic        co,
  output logic [31:0] resa4,
  output logic [31:0] resb4,
  output logic        co4
);

  function automatic step_t step1(input logic [3:0] op, input logic [3:0] sz,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic c);
    logic [31:0] m, top, sl, sr, fa, fb;
    logic        amsb, bmsb;
    step_t       r;
    m    = size_mask(sz);
    top  = m ^ (m >> 1);
    amsb = |(a & top);
    bmsb = |(b & top);
    sl   = (a << 1) & m;
    sr   = (a & m) >> 1;
    fa   = a & m;
    fb   = b & m;
    r.c  = c;
    case (op)
      OP_ROL:  fa = sl | {31'd0, amsb};
      OP_ROR:  fa = sr | (a[0] ? top : 32'd0);
      OP_RCL:  begin fa = sl | {31'd0, c};         r.c = amsb; end
      OP_RCR:  begin fa = sr | (c ? top : 32'd0);  r.c = a[0]; end
      OP_SHL,
      OP_SAL:  begin fa = sl;                      r.c = amsb; end
      OP_SHR:  begin fa = sr;                      r.c = a[0]; end
      OP_SAR:  begin fa = sr | (amsb ? top : 32'd0); r.c = a[0]; end
      OP_SHRD: begin
        fa  = sr;
        fb  = ((b & m) >> 1) | (a[0] ? top : 32'd0);
        r.c = b[0];
      end
      OP_SHLD: begin
        fa  = sl | {31'd0, bmsb};
        fb  = (b << 1) & m;
        r.c = amsb;
      end
      default: ;
    endcase
    r.a = (a & ~m) | (fa & m);
    r.b = (b & ~m) | (fb & m);
    return r;
  endfunction

  step_t s1, s2, s3, s4;

  always_comb begin
    s1 = step1(shiftop, calc_sz, opa, opb, ci);
    s2 = step1(shiftop, calc_sz, s1.a, s1.b, s1.c);
    s3 = step1(shiftop, calc_sz, s2.a, s2.b, s2.c);
    s4 = step1(shiftop, calc_sz, s3.a, s3.b, s3.c);
    resa  = s1.a;
    resb  = s1.b;
    co    = s1.c;
    resa4 = s4.a;
    resb4 = s4.b;
    co4   = s4.c;
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: iterates the shiftbox step unit, 4 bits per cycle then 1.
// Optional build macro: SHIFT_SEQ_RC_MOD_EN (shorter rcl/rcr latency, same results).
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [3:0]  shiftop,
  input  logic [3:0]  calc_sz,
  input  logic [4:0]  count,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        ci,
  output logic [31:0] res_a,
  output logic [31:0] res_b,
  output logic        co,
  output logic        busy,
  output logic        done
);

  state_t      state, next_state;
  logic [3:0]  op_r, sz_r;
  logic [31:0] a_r, b_r;
  logic        c_r;
  logic [4:0]  cnt_r;

  logic [31:0] resa1, resb1, resa4, resb4;
  logic        co1, co4;
  logic [4:0]  n_eff;
  logic        use4, last;
  logic [4:0]  dec;
  logic [31:0] step_a, step_b;
  logic        step_c;

  shiftbox u_step (
    .shiftop (op_r),
    .calc_sz (sz_r),
    .opa     (a_r),
    .opb     (b_r),
    .ci      (c_r),
    .resa    (resa1),
    .resb    (resb1),
    .co      (co1),
    .resa4   (resa4),
    .resb4   (resb4),
    .co4     (co4)
  );

  assign n_eff  = eff_count(shiftop, calc_sz, count);
  assign use4   = (cnt_r >= 5'd4);
  assign dec    = use4 ? 5'd4 : 5'd1;
  assign last   = (cnt_r <= dec);
  assign step_a = use4 ? resa4 : resa1;
  assign step_b = use4 ? resb4 : resb1;
  assign step_c = use4 ? co4 : co1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) next_state = (n_eff == 5'd0) ? ST_DONE : ST_RUN;
          else       next_state = ST_IDLE;
        end
        ST_RUN:  next_state = last ? ST_DONE : ST_RUN;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Working registers and results; a flush freezes everything, including the results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= 4'd0;
      sz_r  <= 4'd0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      c_r   <= 1'b0;
      cnt_r <= 5'd0;
      res_a <= 32'd0;
      res_b <= 32'd0;
      co    <= 1'b0;
    end else if (!flush) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_r  <= shiftop;
            sz_r  <= calc_sz;
            a_r   <= opa;
            b_r   <= opb;
            c_r   <= ci;
            cnt_r <= n_eff;
            if (n_eff == 5'd0) begin
              res_a <= opa;
              res_b <= opb;
              co    <= ci;
            end
          end
        end
        ST_RUN: begin
          a_r   <= step_a;
          b_r   <= step_b;
          c_r   <= step_c;
          cnt_r <= last ? 5'd0 : cnt_r - dec;
          if (last) begin
            res_a <= step_a;
            res_b <= step_b;
            co    <= step_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq with hand-computed expected results.
// Latency expectation for the rcr case follows SHIFT_SEQ_RC_MOD_EN.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  shiftop = 4'd0;
  logic [3:0]  calc_sz = 4'd4;
  logic [4:0]  count = 5'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        ci = 1'b0;
  logic [31:0] res_a, res_b;
  logic        co, busy, done;

  int checks = 0;
  int failures = 0;

  shift_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .shiftop (shiftop),
    .calc_sz (calc_sz),
    .count   (count),
    .opa     (opa),
    .opb     (opb),
    .ci      (ci),
    .res_a   (res_a),
    .res_b   (res_b),
    .co      (co),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [3:0] sz, input logic [4:0] cnt,
                        input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    shiftop = op;
    calc_sz = sz;
    count   = cnt;
    opa     = a;
    opb     = b;
    ci      = c;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [3:0] sz,
                               input logic [4:0] cnt, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input int exp_runs, input logic [31:0] exp_a,
                               input logic [31:0] exp_b, input logic exp_co);
    int  runs;
    bit  seen;
    runs = 0;
    seen = 1'b0;
    launch(op, sz, cnt, a, b, c);
    for (int i = 0; i < 64 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) runs++;
        @(posedge clk);
        #1;
      end
    end
    checkOutput({name, "_done"}, 32'(seen), 32'd1);
    checkOutput({name, "_runs"}, 32'(runs), 32'(exp_runs));
    checkOutput({name, "_res_a"}, res_a, exp_a);
    checkOutput({name, "_res_b"}, res_b, exp_b);
    checkOutput({name, "_co"}, 32'(co), 32'(exp_co));
    @(posedge clk);
    #1;
    checkOutput({name, "_pulse_end"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int exp_rcr_runs;
    bit seen;
`ifdef SHIFT_SEQ_RC_MOD_EN
    exp_rcr_runs = 0;
`else
    exp_rcr_runs = 3;
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_res_a", res_a, 32'd0);
    checkOutput("rst_res_b", res_b, 32'd0);
    checkOutput("rst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("rol_d1", 4'd0, 4'd4, 5'd1, 32'h8000_0001, 32'h0, 1'b0,
                  1, 32'h0000_0003, 32'h0, 1'b0);
    applyStimulus("shl_b5", 4'd4, 4'd1, 5'd5, 32'h0000_00F1, 32'h0, 1'b0,
                  2, 32'h0000_0020, 32'h0, 1'b0);
    applyStimulus("shrd_d4", 4'd8, 4'd4, 5'd4, 32'h0000_000F, 32'h0, 1'b0,
                  1, 32'h0000_0000, 32'hF000_0000, 1'b0);
    applyStimulus("cnt0", 4'd5, 4'd4, 5'd0, 32'h1234_5678, 32'h0000_0055, 1'b1,
                  0, 32'h1234_5678, 32'h0000_0055, 1'b1);
    applyStimulus("rcr_b9", 4'd3, 4'd1, 5'd9, 32'h0000_005A, 32'h0, 1'b1,
                  exp_rcr_runs, 32'h0000_005A, 32'h0, 1'b1);
    applyStimulus("ror_w1", 4'd1, 4'd2, 5'd1, 32'hABCD_0001, 32'h0, 1'b1,
                  1, 32'hABCD_8000, 32'h0, 1'b1);
    applyStimulus("sar_b3", 4'd7, 4'd1, 5'd3, 32'h0000_0080, 32'h0, 1'b0,
                  3, 32'h0000_00F0, 32'h0, 1'b0);
    applyStimulus("shld_w1", 4'd9, 4'd2, 5'd1, 32'h0000_1234, 32'h0000_8000, 1'b0,
                  1, 32'h0000_2469, 32'h0000_0000, 1'b0);
    applyStimulus("shld_d20", 4'd9, 4'd4, 5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0,
                  5, 32'h6789_ABCD, 32'hEF00_0000, 1'b1);

    // Long op, ignored restart in RUN cycle 2, flush in RUN cycle 3.
    launch(4'd4, 4'd4, 5'd31, 32'h0000_0001, 32'h0, 1'b0);
    checkOutput("flush_run1_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("flush_run3_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_done", 32'(done), 32'd0);
    checkOutput("flush_hold_a", res_a, 32'h6789_ABCD);
    checkOutput("flush_hold_co", 32'(co), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1'b1;
    end
    checkOutput("flush_quiet", 32'(seen), 32'd0);

    // Reset in the middle of a run.
    launch(4'd5, 4'd4, 5'd31, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_res_a", res_a, 32'd0);
    checkOutput("midrst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1'b1;
    end
    checkOutput("midrst_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
